// File: rtl/msk_tof_hpc2_pipe_pkg.sv
// Shared constants and index helpers for the masked Toffoli (HPC2) pipeline.
// No timing of its own; pure elaboration-time helpers.
// No flow control; consumed by the interface, lane and top.
package msk_tof_hpc2_pipe_pkg;

    localparam int DEFAULT_SHARES = 2;

    // Fresh random bits needed per lane: one per unordered share pair.
    function automatic int hpc2rnd(input int d);
        return d * (d - 1) / 2;
    endfunction

    // Bit position of r_ij inside a lane's rnd slice; r_ij and r_ji share one bit.
    // The diagonal has no random bit; it maps to 0 so callers may evaluate it harmlessly.
    function automatic int rnd_idx(input int d, input int i, input int j);
        int lo;
        int hi;
        if (i == j) begin
            return 0;
        end
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * d - lo * (lo + 1) / 2 + (hi - 1 - lo);
    endfunction

    // Lowest share index other than i; that cross term also carries a_i&b_i and c_i.
    function automatic int first_peer(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Flat bit position of lane k, share s in a W*d sharing bus.
    function automatic int share_bit(input int d, input int k, input int s);
        return k * d + s;
    endfunction

endpackage

// File: rtl/msk_tof_hpc2_pipe_if.sv
// Operand/result bundle of the masked Toffoli pipeline.
// No latency; plain wires between producer and pipeline.
// en is a global advance: en=0 freezes the whole pipeline, there is no per-beat ready.
interface msk_tof_hpc2_pipe_if
    import msk_tof_hpc2_pipe_pkg::*;
#(
    parameter int d = DEFAULT_SHARES,
    parameter int W = 1
);
    localparam int R = hpc2rnd(d);

    logic             en;
    logic             in_valid;
    logic [W*d-1:0]   ina;
    logic [W*d-1:0]   inb;
    logic [W*d-1:0]   inc;
    logic [W*R-1:0]   rnd;
    logic             out_valid;
    logic [W*d-1:0]   out;

    modport master (
        output en, in_valid, ina, inb, inc, rnd,
        input  out_valid, out
    );

    modport slave (
        input  en, in_valid, ina, inb, inc, rnd,
        output out_valid, out
    );

endinterface

// File: rtl/msk_tof_hpc2_pipe_lane.sv
// One lane of the d-share HPC2 Toffoli gadget: out = (a & b) ^ c on shares.
// Latency 2 en=1 edges (input regs + cross-product regs), output XOR tree is combinational.
// en=0 holds every register; no other backpressure.
module msk_tof_hpc2_pipe_lane
    import msk_tof_hpc2_pipe_pkg::*;
#(
    parameter int d = DEFAULT_SHARES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [d-1:0]            ina,
    input  logic [d-1:0]            inb,
    input  logic [d-1:0]            inc,
    input  logic [hpc2rnd(d)-1:0]   rnd,
    output logic [d-1:0]            out
);
    localparam int R = hpc2rnd(d);

    // Stage-1 registers: aligned copies of a, b, c, rnd plus the refreshed b_j ^ r_ij.
    logic [d-1:0]          a1;
    logic [d-1:0]          b1;
    logic [d-1:0]          c1;
    logic [R-1:0]          r1;
    logic [d-1:0][d-1:0]   v1;

    // Stage-2 registers: per-pair cross terms, kept separate until the output XOR.
    logic [d-1:0][d-1:0]   w2;
    logic [d-1:0][d-1:0]   u2;

    // Stage 1: the b share is masked with r_ij before it ever meets another domain's a.
    always_ff @(posedge clk) begin
        if (rst) begin
            a1 <= '0;
            b1 <= '0;
            c1 <= '0;
            r1 <= '0;
            v1 <= '0;
        end else if (en) begin
            a1 <= ina;
            b1 <= inb;
            c1 <= inc;
            r1 <= rnd;
            for (int i = 0; i < d; i++) begin
                for (int j = 0; j < d; j++) begin
                    if (i == j) begin
                        v1[i][j] <= 1'b0;
                    end else begin
                        v1[i][j] <= inb[j] ^ rnd[rnd_idx(d, i, j)];
                    end
                end
            end
        end
    end

    // Stage 2: a_i&(b_j^r) and ~a_i&r are registered apart so r only cancels after the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            w2 <= '0;
            u2 <= '0;
        end else if (en) begin
            for (int i = 0; i < d; i++) begin
                for (int j = 0; j < d; j++) begin
                    w2[i][j] <= a1[i] & v1[i][j];
                    if (i == j) begin
                        u2[i][j] <= 1'b0;
                    end else if (j == first_peer(i)) begin
                        u2[i][j] <= (~a1[i] & r1[rnd_idx(d, i, j)])
                                    ^ (a1[i] & b1[i]) ^ c1[i];
                    end else begin
                        u2[i][j] <= ~a1[i] & r1[rnd_idx(d, i, j)];
                    end
                end
            end
        end
    end

    // Output share i: XOR of all registered cross terms of domain i (diagonal entries are 0).
    always_comb begin
        out = '0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                out[i] = out[i] ^ u2[i][j] ^ w2[i][j];
            end
        end
    end

endmodule

// File: rtl/msk_tof_hpc2_pipe.sv
// W-lane masked Toffoli pipeline, out = (a & b) ^ c per lane, PINI HPC2 structure.
// Latency 2 en=1 edges; one operand set per en=1 cycle, back-to-back supported.
// en=0 stalls all stages (data and valid hold). Optional MSKTOF_OUT_GATE_EN zeroes out while !out_valid.
module msk_tof_hpc2_pipe
    import msk_tof_hpc2_pipe_pkg::*;
#(
    parameter int d = DEFAULT_SHARES,
    parameter int W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    msk_tof_hpc2_pipe_if.slave    bus
);
    localparam int R = hpc2rnd(d);

    logic [1:0]      vp;
    logic [W*d-1:0]  out_raw;

    // Valid shift register tracking which pipeline slots hold accepted operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            vp <= 2'b00;
        end else if (bus.en) begin
            vp <= {vp[0], bus.in_valid};
        end
    end

    // Independent lanes; each sees only its own share slices and rnd slice.
    for (genvar k = 0; k < W; k++) begin : g_lane
        msk_tof_hpc2_pipe_lane #(.d(d)) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (bus.en),
            .ina (bus.ina[share_bit(d, k, 0) +: d]),
            .inb (bus.inb[share_bit(d, k, 0) +: d]),
            .inc (bus.inc[share_bit(d, k, 0) +: d]),
            .rnd (bus.rnd[k*R +: R]),
            .out (out_raw[share_bit(d, k, 0) +: d])
        );
    end

    assign bus.out_valid = vp[1];

`ifdef MSKTOF_OUT_GATE_EN
    // out_valid is public, so masking the shares with it leaks nothing.
    assign bus.out = out_raw & {(W*d){vp[1]}};
`else
    assign bus.out = out_raw;
`endif

endmodule

// File: tb/tb_msk_tof_hpc2_pipe.sv
// Scoreboard bench for msk_tof_hpc2_pipe at d=3, W=4.
// Expected unmasked results are queued on accept and compared when out_valid advances.
// Covers reset, basic, stall, reset mid-flight, streaming and output gating.
module tb_msk_tof_hpc2_pipe;
    import msk_tof_hpc2_pipe_pkg::*;

    localparam int D  = 3;
    localparam int NL = 4;
    localparam int R  = hpc2rnd(D);
    localparam int BW = NL * D;
    localparam int RW = NL * R;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    msk_tof_hpc2_pipe_if #(.d(D), .W(NL)) bus ();

    msk_tof_hpc2_pipe #(.d(D), .W(NL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int nz_cnt = 0;
    logic [NL-1:0] exp_q[$];

    logic          s_rst;
    logic          s_en;
    logic          s_v;
    logic [BW-1:0] s_a;
    logic [BW-1:0] s_b;
    logic [BW-1:0] s_c;
    logic [NL-1:0] e_val;
    logic [BW-1:0] out_ref;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NL-1:0] unmask(input logic [BW-1:0] x);
        logic [NL-1:0] r;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            r[k] = ^x[k*D +: D];
        end
        return r;
    endfunction

    function automatic logic [NL-1:0] model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                            input logic [BW-1:0] c);
        return (unmask(a) & unmask(b)) ^ unmask(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        logic [31:0] t;
        t = $urandom; bus.ina = t[BW-1:0];
        t = $urandom; bus.inb = t[BW-1:0];
        t = $urandom; bus.inc = t[BW-1:0];
        t = $urandom; bus.rnd = t[RW-1:0];
    endtask

    // Monitor: push on accept, pop when a new result appears after an en=1 edge.
    always begin
        @(posedge clk);
        s_rst = rst;
        s_en  = bus.en;
        s_v   = bus.in_valid;
        s_a   = bus.ina;
        s_b   = bus.inb;
        s_c   = bus.inc;
        if (!s_rst && s_en && s_v) begin
            exp_q.push_back(model(s_a, s_b, s_c));
        end
        #2;
        if (s_rst) begin
            exp_q.delete();
        end else if (s_en && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                e_val = exp_q.pop_front();
                chk("result", 32'(unmask(bus.out)), 32'(e_val));
            end
        end
        if (!bus.out_valid && bus.out != '0) begin
            nz_cnt++;
        end
    end

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.in_valid = 1'b0;
        bus.ina      = '0;
        bus.inb      = '0;
        bus.inc      = '0;
        bus.rnd      = '0;

        // Reset state
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", 32'(bus.out), 32'd0);
        rst = 1'b0;
        step();

        // Basic: lane 0 a=1, b=1, c=0; other lanes all-zero shares
        bus.ina      = BW'(3'b001);
        bus.inb      = BW'(3'b010);
        bus.inc      = BW'(3'b011);
        bus.rnd      = RW'(1);
        bus.in_valid = 1'b1;
        step();
        chk("basic_lat1", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        rand_data();
        step();
        chk("basic_lat2", 32'(bus.out_valid), 32'd1);
        chk("basic_val", 32'(unmask(bus.out)), 32'd1);
        step();
        chk("basic_drop", 32'(bus.out_valid), 32'd0);

        // Stall: accept, hold en=0 for three edges (in_valid high must be ignored), then one en=1 edge
        rand_data();
        bus.in_valid = 1'b1;
        step();
        chk("stall_acc", 32'(bus.out_valid), 32'd0);
        out_ref = bus.out;
        bus.en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
            chk("stall_valid", 32'(bus.out_valid), 32'd0);
            chk("stall_out", 32'(bus.out), 32'(out_ref));
        end
        bus.en       = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk("stall_release", 32'(bus.out_valid), 32'd1);
        out_ref = bus.out;
        // Stall while the result sits at the output
        bus.en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_data();
            step();
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_out", 32'(bus.out), 32'(out_ref));
        end
        bus.en = 1'b1;
        step();
        chk("hold_drop", 32'(bus.out_valid), 32'd0);

        // Reset mid-flight: result must vanish, next input still correct
        rand_data();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
            chk("rst_flight", 32'(bus.out_valid), 32'd0);
        end
        rand_data();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("rst_recover", 32'(bus.out_valid), 32'd1);

        // Streaming: 1000 back-to-back random operands
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rand_data();
            step();
        end
        // Idle with junk data so the stage-2 registers hold non-result contents
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            step();
        end

        // Drain, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            step();
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

`ifdef MSKTOF_OUT_GATE_EN
        chk("gate_zero", 32'(nz_cnt != 0), 32'd0);
`else
        chk("ungated_nonzero", 32'(nz_cnt != 0), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
